// File: rtl/logip_pkg.sv
// logip_pkg: shared constants and helpers for the logic-analyser capture path.
// Holds the default sample width / ring depth and the occupancy-counter width helper.
package logip_pkg;

  localparam int SMPL_WIDTH = 32;
  localparam int MMU_DEPTH  = 4;

  // Operation selected for the current cycle after priority resolution.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_WRITE,
    OP_READ
  } mmu_op_e;

  // Bits needed to count 0..2**depth inclusive (the ring must be able to report "full").
  function automatic int cnt_width(input int depth);
    return $clog2((1 << depth) + 1);
  endfunction

  typedef logic [cnt_width(MMU_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/mmu_ring_ram.sv
// mmu_ring_ram: simple dual-port sample array, one write port and one registered read port.
// The array itself is never reset; only the read-data register returns to zero.
module mmu_ring_ram
  import logip_pkg::*;
#(
  parameter int WIDTH = SMPL_WIDTH,
  parameter int DEPTH = MMU_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  // Sample store: written on every accepted write, contents survive clear and reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: only updates on an accepted read so the last sample is held otherwise.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mmu_ring.sv
// mmu_ring: ring-buffer sample memory keeping the most recent 2**DEPTH samples.
// Writes always succeed and overwrite the oldest sample once full; reads return one
// sample per cycle with one-cycle latency. Define LOGIP_MMU_LIFO_EN for newest-first
// reads (SUMP reverse-order transfer); otherwise reads are oldest-first.
module mmu_ring
  import logip_pkg::*;
#(
  parameter int WIDTH = SMPL_WIDTH,
  parameter int DEPTH = MMU_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             clr_i,
  input  logic             wrt_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o,
  output logic             vld_o,
  output logic [DEPTH:0]   cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int                 CNT_W    = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0]   CAPACITY = CNT_W'(2**DEPTH);

  mmu_op_e           op;
  logic [DEPTH-1:0]  wr_ptr;
  logic [DEPTH-1:0]  wr_ptr_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DEPTH-1:0]  rd_addr;
  logic              vld_q;
  logic              full_q;
  logic              empty_q;

  // Resolve the cycle's operation: clear beats write, write beats read, empty reads vanish.
  always_comb begin
    op = OP_IDLE;
    if (clr_i) begin
      op = OP_CLEAR;
    end else if (wrt_i) begin
      op = OP_WRITE;
    end else if (read_i && (cnt != '0)) begin
      op = OP_READ;
    end
  end

`ifdef LOGIP_MMU_LIFO_EN
  // Newest sample sits just behind the write pointer.
  assign rd_addr = wr_ptr - DEPTH'(1);
`else
  // Oldest sample sits cnt entries behind the write pointer (cnt==N wraps to wr_ptr itself).
  assign rd_addr = wr_ptr - cnt[DEPTH-1:0];
`endif

  // Next pointer and occupancy for the resolved operation.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = cnt;
    case (op)
      OP_CLEAR: begin
        wr_ptr_nxt = '0;
        cnt_nxt    = '0;
      end
      OP_WRITE: begin
        wr_ptr_nxt = wr_ptr + DEPTH'(1);
        if (cnt < CAPACITY) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      OP_READ: begin
        cnt_nxt = cnt - CNT_W'(1);
`ifdef LOGIP_MMU_LIFO_EN
        wr_ptr_nxt = wr_ptr - DEPTH'(1);
`endif
      end
      default: begin
      end
    endcase
  end

  // State and registered flags; flags are derived from the post-edge count.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr  <= '0;
      cnt     <= '0;
      vld_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      cnt     <= cnt_nxt;
      vld_q   <= (op == OP_READ);
      full_q  <= (cnt_nxt == CAPACITY);
      empty_q <= (cnt_nxt == '0);
    end
  end

  mmu_ring_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .we     (op == OP_WRITE),
    .waddr  (wr_ptr),
    .wdata  (d_i),
    .re     (op == OP_READ),
    .raddr  (rd_addr),
    .rdata  (d_o)
  );

  assign vld_o   = vld_q;
  assign cnt_o   = cnt;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule
